sc_mult_array: RTL and testbench

SC_MULT_ARRAY -- requirements
Module: sc_mult_array

---
 rtl/sc_mult_array.sv | 128 ++++++++++++
 tb/tb_sc_mult_array.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_mult_array.sv
// Multi-lane stochastic-computing multiplier: per-lane AND (unipolar) or XNOR (bipolar)
// over a fixed-length frame, with a registered product stream and a per-lane ones count.
module sc_mult_array #(
  parameter  int NUM_CH     = 4,
  parameter  int STREAM_LEN = 256,
  localparam int CNT_W      = $clog2(STREAM_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    bipolar,
  input  logic                    in_valid,
  input  logic [NUM_CH-1:0]       x,
  input  logic [NUM_CH-1:0]       y,
  output logic [NUM_CH-1:0]       res,
  output logic                    res_valid,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(STREAM_LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                    state_q, state_d;
  logic                      mode_q, mode_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [NUM_CH-1:0]         res_q, res_d;
  logic                      res_valid_q, res_valid_d;
  logic [NUM_CH*CNT_W-1:0]   count_q, count_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [NUM_CH-1:0]         prod_s;

  assign prod_s = mode_q ? ~(x ^ y) : (x & y);

  // Next-state and next-output computation for the frame controller and lanes
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    bit_cnt_d   = bit_cnt_q;
    res_d       = res_q;
    res_valid_d = 1'b0;
    count_d     = count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          mode_d    = bipolar;
          bit_cnt_d = '0;
          count_d   = '0;
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end
      RUN: begin
        // Abort wins over a same-cycle bit so a cancelled frame never counts it
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (in_valid) begin
          res_d       = prod_s;
          res_valid_d = 1'b1;
          bit_cnt_d   = bit_cnt_q + ONE;
          for (int i = 0; i < NUM_CH; i++) begin
            count_d[i*CNT_W +: CNT_W] = count_q[i*CNT_W +: CNT_W] + {{(CNT_W-1){1'b0}}, prod_s[i]};
          end
          if (bit_cnt_q == LAST_BIT) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      bit_cnt_q   <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      bit_cnt_q   <= bit_cnt_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sc_mult_array.sv
// Scenario bench for sc_mult_array (2 lanes, 8-bit frames); expected product bits
// are queued when driven and popped as res_valid returns them.
module tb_sc_mult_array;

  localparam int NCH = 2;
  localparam int SL  = 8;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort, bipolar, in_valid;
  logic [NCH-1:0]    x, y;
  logic [NCH-1:0]    res;
  logic              res_valid;
  logic [NCH*CW-1:0] count;
  logic              busy, done;

  int checks = 0;
  int errors = 0;
  logic [NCH-1:0] exp_q[$];
  logic [NCH-1:0] exp_res;

  sc_mult_array #(.NUM_CH(NCH), .STREAM_LEN(SL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bipolar(bipolar),
    .in_valid(in_valid), .x(x), .y(y), .res(res), .res_valid(res_valid),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bipolar = 1'b0; in_valid = 1'b0;
    x = '0; y = '0;
    #3;
    checks++;
    if ({res, res_valid, count, busy, done} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got res=%b rv=%b cnt=%h busy=%b done=%b want all 0", res, res_valid, count, busy, done);
    end
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_unipolar();
    bipolar = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || count !== 8'h00) begin
      errors++;
      $display("FAIL uni_start got busy=%b cnt=%h want busy=1 cnt=00", busy, count);
    end
    for (int i = 0; i < SL; i++) begin
      x = 2'b11; y = 2'b01; in_valid = 1'b1;
      exp_q.push_back(x & y);
      cycle();
      checks++;
      if (res_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL uni_valid bit %0d got rv=%b want 1", i, res_valid);
      end else begin
        exp_res = exp_q.pop_front();
        checks++;
        if (res !== exp_res) begin
          errors++;
          $display("FAIL uni_res bit %0d got %b want %b", i, res, exp_res);
        end
      end
      checks++;
      if (done !== (i == SL-1) || busy !== 1'b1) begin
        errors++;
        $display("FAIL uni_done bit %0d got done=%b busy=%b want done=%b busy=1", i, done, busy, (i == SL-1));
      end
    end
    checks++;
    if (count !== 8'h08) begin
      errors++;
      $display("FAIL uni_count got %h want 08", count);
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0 || count !== 8'h08) begin
      errors++;
      $display("FAIL uni_after got busy=%b done=%b rv=%b cnt=%h want 0 0 0 08", busy, done, res_valid, count);
    end
  endtask

  task automatic test_bipolar();
    logic a;
    bipolar = 1'b1; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < SL; i++) begin
      a = (i % 2 == 0);
      x = {~a, a}; y = {a, a}; in_valid = 1'b1;
      // mode flip and a repeated start mid-frame must both be ignored
      bipolar = (i >= 3) ? 1'b0 : 1'b1;
      start   = (i == 2);
      exp_q.push_back(~(x ^ y));
      cycle();
      if (res_valid !== 1'b1 || exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bip_valid bit %0d got rv=%b want 1", i, res_valid);
      end else begin
        exp_res = exp_q.pop_front();
        checks++;
        if (res !== exp_res) begin
          errors++;
          $display("FAIL bip_res bit %0d got %b want %b", i, res, exp_res);
        end
      end
      checks++;
      if (done !== (i == SL-1)) begin
        errors++;
        $display("FAIL bip_done bit %0d got %b want %b", i, done, (i == SL-1));
      end
    end
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if (count !== 8'h08) begin
      errors++;
      $display("FAIL bip_count got %h want 08", count);
    end
    cycle();
  endtask

  task automatic test_gapped();
    int nvalid = 0;
    int k = 0;
    logic v;
    bipolar = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    while (nvalid < SL && k < 64) begin
      v = (k % 3 == 0);
      in_valid = v; x = 2'b11; y = 2'b10;
      if (v) exp_q.push_back(x & y);
      cycle();
      if (v) nvalid++;
      checks++;
      if (res_valid !== v) begin
        errors++;
        $display("FAIL gap_valid cycle %0d got %b want %b", k, res_valid, v);
      end
      if (res_valid === 1'b1 && exp_q.size() != 0) begin
        exp_res = exp_q.pop_front();
        checks++;
        if (res !== exp_res) begin
          errors++;
          $display("FAIL gap_res cycle %0d got %b want %b", k, res, exp_res);
        end
      end
      checks++;
      if (done !== (v && nvalid == SL)) begin
        errors++;
        $display("FAIL gap_done cycle %0d got %b want %b", k, done, (v && nvalid == SL));
      end
      k++;
    end
    in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      cycle();
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 8'h80) begin
        errors++;
        $display("FAIL gap_idle_ignore %0d got rv=%b busy=%b done=%b cnt=%h want 0 0 0 80", j, res_valid, busy, done, count);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    bipolar = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = 2'b11; y = 2'b11; in_valid = 1'b1;
      exp_q.push_back(x & y);
      cycle();
      if (exp_q.size() != 0) exp_res = exp_q.pop_front();
      checks++;
      if (res_valid !== 1'b1 || res !== exp_res) begin
        errors++;
        $display("FAIL abort_pre bit %0d got rv=%b res=%b want 1 %b", i, res_valid, res, exp_res);
      end
    end
    abort = 1'b1;
    cycle();
    abort = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0 || count !== 8'h44) begin
      errors++;
      $display("FAIL abort_stop got busy=%b done=%b rv=%b cnt=%h want 0 0 0 44", busy, done, res_valid, count);
    end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || count !== 8'h44) begin
      errors++;
      $display("FAIL abort_idle got busy=%b cnt=%h want 0 44", busy, count);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || count !== 8'h00) begin
      errors++;
      $display("FAIL abort_restart got busy=%b cnt=%h want 1 00", busy, count);
    end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    bipolar = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = 2'b11; y = 2'b11; in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({res, res_valid, count, busy, done} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid got res=%b rv=%b cnt=%h busy=%b done=%b want all 0", res, res_valid, count, busy, done);
    end
    #1 rst_n = 1'b1;
    exp_q.delete();
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < SL; i++) begin
      x = 2'b01; y = 2'b11; in_valid = 1'b1;
      exp_q.push_back(x & y);
      cycle();
      if (exp_q.size() != 0) exp_res = exp_q.pop_front();
      checks++;
      if (res_valid !== 1'b1 || res !== exp_res || done !== (i == SL-1)) begin
        errors++;
        $display("FAIL post_reset bit %0d got rv=%b res=%b done=%b want 1 %b %b", i, res_valid, res, done, exp_res, (i == SL-1));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 8'h08) begin
      errors++;
      $display("FAIL post_reset_count got %h want 08", count);
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_unipolar();
    test_bipolar();
    test_gapped();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
